// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Fetches 16-bit instruction words, presents the decoded fields to decode/execute
// through a valid/ready handshake, and computes the next PC from the jump and
// branch inputs that the control decoder and datapath supply on acceptance.
//
// Ports
//   clk_i, reset_i        clock, asynchronous active-high reset
//   imem_req_o/addr_o     instruction-memory request and word address (= PC)
//   imem_ack_i/data_i     memory response; data valid only with ack
//   instr_valid_o         decoded fields are presented
//   instr_ready_i         consumer accepts the presented instruction
//   opcode_o .. imm3_o    fields of the held instruction register
//   pc_out_o              address of the presented instruction
//   jump_i, branch_i,
//   branch_taken_i,
//   jump_target_i         control/datapath inputs, sampled only on acceptance
//   halted_o              a halt (opcode 0) has been retired
//   retired_count_o       accepted instructions, saturating
//
// state  | meaning
// IDLE   | one quiet cycle after reset, no handshakes
// FETCH  | request imem at pc until ack
// ISSUE  | present instruction until accepted
// HALT   | halt retired, parked until reset
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [3:0]  opcode_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rs1_o,
  output logic [2:0]  rs2_o,
  output logic [5:0]  imm6_o,
  output logic [2:0]  imm3_o,
  output logic [15:0] pc_out_o,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic        branch_taken_i,
  input  logic [15:0] jump_target_i,
  output logic        halted_o,
  output logic [15:0] retired_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] OP_HALT = 4'b0000;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic [15:0] imm3_sext;

  assign imm3_sext = {{13{ir_q[2]}}, ir_q[2:0]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      // ack is only meaningful here; in every other state it is ignored
      S_FETCH: begin
        if (imem_ack_i) begin
          ir_d    = imem_data_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (instr_ready_i) begin
          if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
          if (ir_q[15:12] == OP_HALT) begin
            // halt keeps its own PC so pc_out_o still names it
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
            if (jump_i)                          pc_d = jump_target_i;
            else if (branch_i && branch_taken_i) pc_d = pc_q + 16'd1 + imm3_sext;
            else                                 pc_d = pc_q + 16'd1;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req_o      = (state_q == S_FETCH);
  assign imem_addr_o     = pc_q;
  assign instr_valid_o   = (state_q == S_ISSUE);
  assign halted_o        = (state_q == S_HALT);
  assign pc_out_o        = pc_q;
  assign retired_count_o = retired_q;

  assign opcode_o = ir_q[15:12];
  assign rd_o     = ir_q[11:9];
  assign rs1_o    = ir_q[8:6];
  assign rs2_o    = ir_q[5:3];
  assign imm6_o   = ir_q[5:0];
  assign imm3_o   = ir_q[2:0];

endmodule
